// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg
// Shared definitions for the FP operation sequencer slice:
//   - ALU op code constants and sticky/per-op flag bit positions
//   - quiet-NaN patterns returned when the watchdog fires
//   - sequencer FSM state enum
//   - request-entry struct stored in the request FIFO
package fp_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Flag vector layout: {invalid, div0, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV0      = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam logic [31:0] QNAN_SINGLE = 32'h7FC0_0000;
  localparam logic [31:0] QNAN_HALF   = 32'h7E00_0000;

  // Entries carry a tag field wide enough for any supported TAG_W; the
  // sequencer only uses the low TAG_W bits.
  localparam int MAX_TAG_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [2:0]           op;
    logic                 mode;
    logic                 round;
  } req_entry_t;

  // Default result when the ALU never answers: a quiet NaN in the
  // precision the operation was issued with.
  function automatic logic [31:0] timeout_nan(input logic mode);
    return mode ? QNAN_SINGLE : QNAN_HALF;
  endfunction

endpackage

// File: rtl/fp_op_sequencer_if.sv
// fp_op_sequencer_if
// Bundles the request port, the ALU-facing port, the result port and the
// sticky/count status of the FP op sequencer.
//   slave  : the sequencer's view (takes requests and ALU answers, drives
//            ALU controls, results and status)
//   master : the environment's view (producer, ALU and consumer)
interface fp_op_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [2:0]       req_op;
  logic             req_mode;
  logic             req_round;

  logic             alu_start;
  logic [31:0]      alu_op_a;
  logic [31:0]      alu_op_b;
  logic [2:0]       alu_op_code;
  logic             alu_mode_fp;
  logic             alu_round_mode;
  logic [31:0]      alu_result;
  logic             alu_valid_out;
  logic [4:0]       alu_flags;

  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;
  logic [4:0]       res_flags;
  logic             res_timeout;

  logic [4:0]       sticky_flags;
  logic             clr_sticky;
  logic [15:0]      op_count;

  modport slave (
    input  req_valid, req_tag, req_a, req_b, req_op, req_mode, req_round,
    input  alu_result, alu_valid_out, alu_flags,
    input  res_ready, clr_sticky,
    output req_ready,
    output alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode,
    output res_valid, res_tag, res_data, res_flags, res_timeout,
    output sticky_flags, op_count
  );

  modport master (
    output req_valid, req_tag, req_a, req_b, req_op, req_mode, req_round,
    output alu_result, alu_valid_out, alu_flags,
    output res_ready, clr_sticky,
    input  req_ready,
    input  alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode,
    input  res_valid, res_tag, res_data, res_flags, res_timeout,
    input  sticky_flags, op_count
  );

endinterface

// File: rtl/fp_req_fifo.sv
// fp_req_fifo
// Synchronous DEPTH-entry FIFO of request entries with async reset.
//   clk, rst     : clock, async active-high reset (empties the FIFO)
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : advance the read pointer (ignored when empty)
//   pop_data_o   : entry at the head
//   full_o       : no room for another push
//   empty_o      : no entry visible to the read side
module fp_req_fifo
  import fp_alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  req_entry_t push_data_i,
  input  logic       pop_i,
  output req_entry_t pop_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);

  req_entry_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] wr_vis_q;

  // The read side compares against a one-cycle-delayed copy of the write
  // pointer, so a freshly written entry is never popped on the edge right
  // after its write and the pop decision never sees same-cycle storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_vis_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      wr_vis_q <= wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_vis_q == rd_ptr_q);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer
// Issue stage in front of the FP ALU: queues tagged requests, issues them
// one at a time, holds alu_start until the ALU answers (or a watchdog
// expires), and returns each result with its tag on a valid/ready port.
// Also keeps sticky IEEE flags and a wrapping count of completed ops.
//   clk, rst : clock, async active-high reset
//   bus      : fp_op_sequencer_if.slave (request, ALU, result, status)
module fp_op_sequencer
  import fp_alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  fp_op_sequencer_if.slave  bus
);

  localparam int                WDOG_W    = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

  req_entry_t push_entry;
  req_entry_t pop_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       capture;
  logic [4:0] cap_flags;
  logic       unused_tag_hi;

  seq_state_e        state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              start_q, start_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [2:0]        op_code_q, op_code_d;
  logic              mode_q, mode_d;
  logic              round_q, round_d;
  logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
  logic              res_valid_q, res_valid_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [31:0]       res_data_q, res_data_d;
  logic [4:0]        res_flags_q, res_flags_d;
  logic              res_timeout_q, res_timeout_d;
  logic [4:0]        sticky_q, sticky_d;
  logic [15:0]       count_q, count_d;

  always_comb begin
    push_entry       = '0;
    push_entry.tag   = MAX_TAG_W'(bus.req_tag);
    push_entry.a     = bus.req_a;
    push_entry.b     = bus.req_b;
    push_entry.op    = bus.req_op;
    push_entry.mode  = bus.req_mode;
    push_entry.round = bus.req_round;
  end

  assign push = bus.req_valid && !fifo_full;

  fp_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .pop_data_o (pop_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Tag bits above TAG_W are always zero from the push side.
  assign unused_tag_hi = ^(pop_entry.tag >> TAG_W);

  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    start_d       = start_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_code_d     = op_code_q;
    mode_d        = mode_q;
    round_d       = round_q;
    issue_tag_d   = issue_tag_q;
    res_valid_d   = res_valid_q;
    res_tag_d     = res_tag_q;
    res_data_d    = res_data_q;
    res_flags_d   = res_flags_q;
    res_timeout_d = res_timeout_q;
    count_d       = count_q;
    pop           = 1'b0;
    capture       = 1'b0;
    cap_flags     = '0;

    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;

    unique case (state_q)
      // Only pop when the result slot is free (or being freed this edge),
      // so a new capture can never overwrite an unaccepted result.
      S_IDLE: begin
        if (!fifo_empty && (!res_valid_q || bus.res_ready)) begin
          pop         = 1'b1;
          op_a_d      = pop_entry.a;
          op_b_d      = pop_entry.b;
          op_code_d   = pop_entry.op;
          mode_d      = pop_entry.mode;
          round_d     = pop_entry.round;
          issue_tag_d = pop_entry.tag[TAG_W-1:0];
          start_d     = 1'b1;
          wdog_d      = '0;
          state_d     = S_ISSUE;
        end
      end
      // A real answer wins over a watchdog expiry in the same cycle.
      S_ISSUE: begin
        if (bus.alu_valid_out) begin
          capture       = 1'b1;
          res_data_d    = bus.alu_result;
          cap_flags     = bus.alu_flags;
          res_timeout_d = 1'b0;
        end else if (wdog_q == WDOG_LAST) begin
          capture                 = 1'b1;
          res_data_d              = timeout_nan(mode_q);
          cap_flags[FLAG_INVALID] = 1'b1;
          res_timeout_d           = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
        if (capture) begin
          res_valid_d = 1'b1;
          res_flags_d = cap_flags;
          res_tag_d   = issue_tag_q;
          start_d     = 1'b0;
          count_d     = count_q + 16'd1;
          state_d     = S_DRAIN;
        end
      end
      // Let the ALU drop valid_out before issuing again.
      S_DRAIN: begin
        if (!bus.alu_valid_out) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flags captured alongside a clear survive it.
    sticky_d = (bus.clr_sticky ? 5'b0 : sticky_q) | cap_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wdog_q        <= '0;
      start_q       <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_code_q     <= '0;
      mode_q        <= 1'b0;
      round_q       <= 1'b0;
      issue_tag_q   <= '0;
      res_valid_q   <= 1'b0;
      res_tag_q     <= '0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      res_timeout_q <= 1'b0;
      sticky_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      start_q       <= start_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_code_q     <= op_code_d;
      mode_q        <= mode_d;
      round_q       <= round_d;
      issue_tag_q   <= issue_tag_d;
      res_valid_q   <= res_valid_d;
      res_tag_q     <= res_tag_d;
      res_data_q    <= res_data_d;
      res_flags_q   <= res_flags_d;
      res_timeout_q <= res_timeout_d;
      sticky_q      <= sticky_d;
      count_q       <= count_d;
    end
  end

  assign bus.req_ready      = !fifo_full;
  assign bus.alu_start      = start_q;
  assign bus.alu_op_a       = op_a_q;
  assign bus.alu_op_b       = op_b_q;
  assign bus.alu_op_code    = op_code_q;
  assign bus.alu_mode_fp    = mode_q;
  assign bus.alu_round_mode = round_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_tag        = res_tag_q;
  assign bus.res_data       = res_data_q;
  assign bus.res_flags      = res_flags_q;
  assign bus.res_timeout    = res_timeout_q;
  assign bus.sticky_flags   = sticky_q;
  assign bus.op_count       = count_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb_fp_op_sequencer
// Self-checking bench for fp_op_sequencer. A behavioural ALU stub answers
// issued operations after a random latency (or never, for watchdog tests);
// a queue-based reference model predicts every returned result, tag,
// flag vector, op count and sticky value.
module tb_fp_op_sequencer;
  import fp_alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       op;
    logic             mode;
    logic             round;
  } reqRec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [4:0]       flags;
    logic             timeout;
  } resRec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_op_sequencer_if #(.TAG_W(TAG_W)) bus ();

  fp_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checkCount = 0;
  int failCount  = 0;

  reqRec_t curReq;
  reqRec_t acceptedQ[$];
  resRec_t expQ[$];
  logic [4:0] stickyExp;
  int  resultsDone;
  int  issueCount;
  int  acceptTotal;
  bit  lastAccepted;
  bit  readyRandom;
  bit  aluHang;
  bit  clrOnCapture;
  int  aluPhase;
  int  aluDelay;
  int  aluHold;
  int  startCycles;
  bit  justCaptured;
  logic [31:0] aluRes;
  logic [4:0]  aluFlg;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference ALU: a few exact IEEE cases used by the directed tests,
  // otherwise an arbitrary but deterministic mix of the operands.
  function automatic logic [36:0] aluRef(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, 5'b00000};
    if (op == OP_DIV && a == 32'h3F80_0000 && b == 32'h0000_0000) return {32'h7F80_0000, 5'b01000};
    if (op == OP_MUL && a == 32'h4000_0000 && b == 32'h4000_0000) return {32'h4080_0000, 5'b00000};
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h3380_0000) return {32'h3F80_0000, 5'b00001};
    return {a ^ {b[15:0], b[31:16]}, a[4:0] ^ b[9:5]};
  endfunction

  // ALU stub, evaluated once per cycle on the falling edge.
  task automatic aluStub();
    reqRec_t r;
    resRec_t e;
    case (aluPhase)
      0: begin
        if (bus.alu_start) begin
          issueCount++;
          startCycles = 1;
          if (acceptedQ.size() == 0) begin
            checkOutput("issueUnexpected", 32'd1, 32'd0);
          end else begin
            r = acceptedQ.pop_front();
            checkOutput("issueOpA", bus.alu_op_a, r.a);
            checkOutput("issueOpB", bus.alu_op_b, r.b);
            checkOutput("issueCtl", {27'd0, bus.alu_op_code, bus.alu_mode_fp, bus.alu_round_mode},
                        {27'd0, r.op, r.mode, r.round});
            e.tag = r.tag;
            if (aluHang) begin
              e.data    = r.mode ? 32'h7FC0_0000 : 32'h7E00_0000;
              e.flags   = 5'b10000;
              e.timeout = 1'b1;
            end else begin
              {e.data, e.flags} = aluRef(r.op, r.a, r.b);
              e.timeout = 1'b0;
            end
            aluRes = e.data;
            aluFlg = e.flags;
            expQ.push_back(e);
          end
          aluDelay = $urandom_range(0, 3);
          aluPhase = 1;
        end
      end
      1: begin
        if (!bus.alu_start) begin
          if (aluHang) checkOutput("startCycles", startCycles, TIMEOUT);
          else         checkOutput("startEarlyDrop", 32'd0, 32'd1);
          aluPhase = 0;
        end else if (aluHang) begin
          startCycles++;
        end else if (aluDelay == 0) begin
          bus.alu_valid_out = 1'b1;
          bus.alu_result    = aluRes;
          bus.alu_flags     = aluFlg;
          if (clrOnCapture) begin
            bus.clr_sticky = 1'b1;
            stickyExp      = '0;
          end
          aluHold      = $urandom_range(1, 3);
          justCaptured = 1'b1;
          aluPhase     = 2;
        end else begin
          aluDelay--;
        end
      end
      default: begin
        if (justCaptured) begin
          checkOutput("startDropAfterValid", bus.alu_start, 1'b0);
          checkOutput("resultLatency", bus.res_valid, 1'b1);
          justCaptured   = 1'b0;
          bus.clr_sticky = 1'b0;
        end
        aluHold--;
        if (aluHold == 0) begin
          bus.alu_valid_out = 1'b0;
          aluPhase = 0;
        end
      end
    endcase
  endtask

  // One clock: stub + handshake bookkeeping on the falling edge, then the
  // rising edge, returning on the next falling edge.
  task automatic clockEdge();
    resRec_t e;
    aluStub();
    if (readyRandom) bus.res_ready = ($urandom_range(0, 3) != 0);
    if (bus.res_valid && bus.res_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("resultUnexpected", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        stickyExp = stickyExp | e.flags;
        checkOutput("resTag", bus.res_tag, e.tag);
        checkOutput("resData", bus.res_data, e.data);
        checkOutput("resFlags", bus.res_flags, e.flags);
        checkOutput("resTimeout", bus.res_timeout, e.timeout);
        checkOutput("opCount", bus.op_count, 32'(16'(resultsDone + 1)));
        checkOutput("stickyFlags", bus.sticky_flags, stickyExp);
      end
      resultsDone++;
    end
    lastAccepted = bus.req_valid && bus.req_ready;
    if (lastAccepted) begin
      acceptedQ.push_back(curReq);
      acceptTotal++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [TAG_W-1:0] tag,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic mode, input logic round);
    curReq.tag = tag; curReq.a = a; curReq.b = b;
    curReq.op = op; curReq.mode = mode; curReq.round = round;
    bus.req_valid = valid;
    bus.req_tag   = tag;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_mode  = mode;
    bus.req_round = round;
  endtask

  task automatic sendReq(input logic [TAG_W-1:0] tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op,
                         input logic mode, input logic round);
    int n;
    applyStimulus(1'b1, tag, a, b, op, mode, round);
    n = 0;
    do begin
      clockEdge();
      n++;
    end while (!lastAccepted && n < 500);
    if (!lastAccepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while ((acceptedQ.size() != 0 || expQ.size() != 0 || bus.alu_start ||
            bus.res_valid || aluPhase != 0) && n < maxCycles) begin
      clockEdge();
      n++;
    end
    if (n >= maxCycles) checkOutput("drainTimeout", 32'd0, 32'd1);
  endtask

  task automatic clearModel();
    acceptedQ.delete();
    expQ.delete();
    stickyExp    = '0;
    resultsDone  = 0;
    aluPhase     = 0;
    aluHang      = 1'b0;
    clrOnCapture = 1'b0;
    justCaptured = 1'b0;
    bus.alu_valid_out = 1'b0;
    bus.clr_sticky    = 1'b0;
    bus.req_valid     = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    bus.res_ready = 1'b1; bus.alu_result = '0; bus.alu_flags = '0;
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    readyRandom = 1'b0; issueCount = 0; acceptTotal = 0;
    clearModel();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rstReqReady", bus.req_ready, 1'b1);
    checkOutput("rstAluStart", bus.alu_start, 1'b0);
    checkOutput("rstResValid", bus.res_valid, 1'b0);
    checkOutput("rstOpCount", bus.op_count, 32'd0);
    checkOutput("rstSticky", bus.sticky_flags, 32'd0);
    checkOutput("rstResData", bus.res_data, 32'd0);

    $display("[TB] single ADD with issue latency");
    applyStimulus(1'b1, 4'd3, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 1'b1, 1'b0);
    clockEdge();
    bus.req_valid = 1'b0;
    checkOutput("latencyEdge0", bus.alu_start, 1'b0);
    clockEdge();
    checkOutput("latencyEdge1", bus.alu_start, 1'b0);
    clockEdge();
    checkOutput("latencyEdge2", bus.alu_start, 1'b1);
    waitIdle(200);
    checkOutput("addOpCount", bus.op_count, 32'd1);

    $display("[TB] DIV by zero then MUL, sticky flags");
    sendReq(4'd4, 32'h3F80_0000, 32'h0000_0000, OP_DIV, 1'b1, 1'b0);
    waitIdle(200);
    sendReq(4'd5, 32'h4000_0000, 32'h4000_0000, OP_MUL, 1'b1, 1'b0);
    waitIdle(200);
    checkOutput("stickyHeld", bus.sticky_flags, 32'h08);
    bus.clr_sticky = 1'b1;
    clockEdge();
    bus.clr_sticky = 1'b0;
    stickyExp = '0;
    checkOutput("stickyCleared", bus.sticky_flags, 32'd0);

    $display("[TB] backpressure");
    bus.res_ready = 1'b0;
    base = issueCount;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, TAG_W'(i), $urandom, $urandom, 3'($urandom_range(0, 3)), 1'b1, 1'b0);
      checkOutput($sformatf("bpReady%0d", i), bus.req_ready, (i == 5) ? 1'b0 : 1'b1);
      if (i < 5) clockEdge();
    end
    repeat (30) clockEdge();
    checkOutput("bpSingleIssue", issueCount - base, 32'd1);
    checkOutput("bpStillFull", bus.req_ready, 1'b0);
    base = acceptTotal;
    bus.res_ready = 1'b1;
    n = 0;
    while (acceptTotal == base && n < 500) begin
      clockEdge();
      n++;
    end
    checkOutput("bpSixthAccepted", acceptTotal - base, 32'd1);
    bus.req_valid = 1'b0;
    waitIdle(500);

    $display("[TB] watchdog timeout");
    aluHang = 1'b1;
    sendReq(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, OP_DIV, 1'b1, 1'b0);
    waitIdle(300);
    sendReq(4'd10, 32'h1111_2222, 32'h3333_4444, OP_SUB, 1'b0, 1'b1);
    waitIdle(300);
    aluHang = 1'b0;
    sendReq(4'd11, 32'h4000_0000, 32'h4000_0000, OP_MUL, 1'b1, 1'b0);
    waitIdle(300);

    $display("[TB] randomized traffic");
    readyRandom = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) clockEdge();
      sendReq(TAG_W'($urandom), $urandom, $urandom, 3'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom));
    end
    readyRandom = 1'b0;
    bus.res_ready = 1'b1;
    waitIdle(2000);

    $display("[TB] clear coinciding with capture");
    sendReq(4'd1, 32'h3F80_0000, 32'h0000_0000, OP_DIV, 1'b1, 1'b0);
    waitIdle(200);
    clrOnCapture = 1'b1;
    sendReq(4'd2, 32'h3F80_0000, 32'h3380_0000, OP_ADD, 1'b1, 1'b0);
    waitIdle(200);
    clrOnCapture = 1'b0;
    checkOutput("stickyClrCapture", bus.sticky_flags, 32'h01);

    $display("[TB] reset mid-issue");
    aluHang = 1'b1;
    base = issueCount;
    sendReq(4'd6, 32'h0000_1111, 32'h0000_2222, OP_ADD, 1'b1, 1'b0);
    sendReq(4'd7, 32'h0000_3333, 32'h0000_4444, OP_SUB, 1'b1, 1'b0);
    sendReq(4'd8, 32'h0000_5555, 32'h0000_6666, OP_MUL, 1'b1, 1'b0);
    n = 0;
    while (issueCount == base && n < 50) begin
      clockEdge();
      n++;
    end
    checkOutput("midIssueStarted", bus.alu_start, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncStartDrop", bus.alu_start, 1'b0);
    checkOutput("asyncResValid", bus.res_valid, 1'b0);
    checkOutput("asyncReqReady", bus.req_ready, 1'b1);
    checkOutput("asyncOpCount", bus.op_count, 32'd0);
    clearModel();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sendReq(4'd12, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 1'b1, 1'b0);
    waitIdle(200);
    checkOutput("postResetOpCount", bus.op_count, 32'd1);
    repeat (10) clockEdge();
    checkOutput("postResetNoStaleIssue", bus.alu_start, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
